// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, FSM state type and helpers for regfile_mp
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Fallback for tools without $clog2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file access bus: clear handshake, read ports, two write ports
interface regfile_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);

  logic                 clr;
  logic                 ready;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [1:0]           wr_en;
  logic [2*AW-1:0]      wr_addr;
  logic [2*DW-1:0]      wr_data;

  modport master (
    output clr,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  ready,
    input  rd_data
  );

  modport slave (
    input  clr,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output ready,
    output rd_data
  );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with zero/ready masking and write bypass
module regfile_rd_port #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            i_ready,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [DW-1:0]   i_stored,
  input  logic [1:0]      i_wr_en,
  input  logic [2*AW-1:0] i_wr_addr,
  input  logic [2*DW-1:0] i_wr_data,
  output logic [DW-1:0]   o_rd_data
);

  logic [1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int p = 0; p < 2; p++) begin
      w_hit[p] = (BYPASS != 0) && i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_rd_addr);
    end

    // Port 1 wins a same-address conflict, so it must also win the bypass.
    o_rd_data = i_stored;
    if (w_hit[1]) begin
      o_rd_data = i_wr_data[DW +: DW];
    end else if (w_hit[0]) begin
      o_rd_data = i_wr_data[0 +: DW];
    end

    if (!i_ready || (i_rd_addr == '0)) begin
      o_rd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, register 0 hard-wired to zero, sequential clear engine
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_clr_ptr;
  logic [AW-1:0]       w_clr_ptr_nxt;
  logic [DW-1:0]       r_mem [DEPTH];
  logic                w_ready;
  logic [NUM_RD*DW-1:0] w_rd_data;

  assign w_ready   = (r_state == RUN);
  assign bus.ready = w_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= AW'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // The walk parks on DEPTH-1 instead of wrapping; a new clear reloads it.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      CLEAR: begin
        if (r_clr_ptr == AW'(DEPTH - 1)) begin
          w_state_nxt = RUN;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + AW'(1);
        end
      end
      RUN: begin
        if (bus.clr) begin
          w_state_nxt   = CLEAR;
          w_clr_ptr_nxt = AW'(1);
        end
      end
      default: begin
        w_state_nxt   = CLEAR;
        w_clr_ptr_nxt = AW'(1);
      end
    endcase
  end

  // Array has no reset; the clear walk is what makes it valid.
  // Port 1 is written last so it overrides port 0 on an address conflict.
  always_ff @(posedge i_clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0)) begin
          r_mem[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*DW +: DW];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_stored;

    assign w_addr   = bus.rd_addr[k*AW +: AW];
    assign w_stored = r_mem[w_addr];

    regfile_rd_port #(
      .DW     (DW),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd_port (
      .i_ready   (w_ready),
      .i_rd_addr (w_addr),
      .i_stored  (w_stored),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_rd_data (w_rd_data[k*DW +: DW])
    );
  end

  assign bus.rd_data = w_rd_data;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp in three configurations
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;
  logic rst2;

  regfile_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) bus0 ();
  regfile_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) bus1 ();
  regfile_mp_if #(.DW(16), .AW(3), .NUM_RD(4)) bus2 ();

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) u_dut0 (
    .i_clk (clk), .i_rst_n (rst0), .bus (bus0)
  );
  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) u_dut1 (
    .i_clk (clk), .i_rst_n (rst1), .bus (bus1)
  );
  regfile_mp #(.DW(16), .DEPTH(8), .NUM_RD(4), .BYPASS(1)) u_dut2 (
    .i_clk (clk), .i_rst_n (rst2), .bus (bus2)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  int          n0, n1, n2, zbad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    checks++;
    if (sb_q.size() == 0) exp = ~obs;
    else exp = sb_q.pop_front();
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic drv0(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
    bus0.wr_en = en; bus0.wr_addr = {a1, a0}; bus0.wr_data = {d1, d0};
  endtask

  task automatic drv1(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
    bus1.wr_en = en; bus1.wr_addr = {a1, a0}; bus1.wr_data = {d1, d0};
  endtask

  task automatic drv2(input logic [1:0] en, input logic [2:0] a0, input logic [15:0] d0,
                      input logic [2:0] a1, input logic [15:0] d1);
    bus2.wr_en = en; bus2.wr_addr = {a1, a0}; bus2.wr_data = {d1, d0};
  endtask

  task automatic read_all_zero0(input string tag);
    for (int a = 0; a < 32; a++) begin
      bus0.rd_addr = {5'(31 - a), 5'(a)};
      #1;
      push(64'h0);
      pop_check(tag, bus0.rd_data);
      tick();
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    bus0.clr = 1'b0; bus1.clr = 1'b0; bus2.clr = 1'b0;
    bus0.rd_addr = '0; bus1.rd_addr = '0; bus2.rd_addr = '0;
    drv0(2'b00, 0, 0, 0, 0); drv1(2'b00, 0, 0, 0, 0); drv2(2'b00, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset state
    bus0.rd_addr = {5'd5, 5'd1};
    #1;
    push(64'h0); pop_check("rst_ready", bus0.ready);
    push(64'h0); pop_check("rst_rd_data", bus0.rd_data);

    // Initial clear length on all three instances
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      n0 += bus0.ready ? 0 : 1;
      n1 += bus1.ready ? 0 : 1;
      n2 += bus2.ready ? 0 : 1;
      tick();
    end
    push(64'd31); pop_check("init_clear_len0", n0);
    push(64'd31); pop_check("init_clear_len1", n1);
    push(64'd7);  pop_check("init_clear_len2", n2);

    // Garbage preload, then reset must wipe it
    for (int i = 1; i < 32; i += 2) begin
      drv0(2'b11, 5'(i), 32'hA5A50000 | i, 5'(i + 1), 32'hA5A50000 | (i + 1));
      tick();
    end
    drv0(2'b00, 0, 0, 0, 0);
    bus0.rd_addr = {5'd31, 5'd1};
    #1;
    push({32'hA5A5001F, 32'hA5A50001}); pop_check("garbage", bus0.rd_data);
    rst0 = 1'b0;
    tick();
    rst0 = 1'b1;
    n0 = 0;
    while (!bus0.ready && n0 < 100) begin tick(); n0++; end
    push(64'd31); pop_check("reset_clear_len", n0);
    read_all_zero0("wiped_after_reset");

    // Single write, and write to register 0
    drv0(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    push({32'h0, 32'hDEADBEEF});
    tick();
    drv0(2'b00, 0, 0, 0, 0);
    bus0.rd_addr = {5'd0, 5'd5};
    #1;
    pop_check("wr_addr5", bus0.rd_data);
    drv0(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0);
    push(64'h0);
    tick();
    drv0(2'b00, 0, 0, 0, 0);
    bus0.rd_addr = {5'd0, 5'd0};
    #1;
    pop_check("wr_addr0_dropped", bus0.rd_data);

    // Write conflict and bypass vs no bypass
    drv0(2'b01, 5'd7, 32'h5555, 5'd0, 32'h0);
    drv1(2'b01, 5'd7, 32'h5555, 5'd0, 32'h0);
    tick();
    drv0(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222);
    drv1(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222);
    bus0.rd_addr = {5'd0, 5'd7};
    bus1.rd_addr = {5'd0, 5'd7};
    #1;
    push(64'h2222); pop_check("bypass_same_cycle", bus0.rd_data);
    push(64'h5555); pop_check("nobypass_same_cycle", bus1.rd_data);
    push(64'h2222); push(64'h2222);
    tick();
    drv0(2'b00, 0, 0, 0, 0);
    drv1(2'b00, 0, 0, 0, 0);
    #1;
    pop_check("conflict_p1_wins", bus0.rd_data);
    pop_check("nobypass_next_cycle", bus1.rd_data);
    drv0(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    bus0.rd_addr = {5'd9, 5'd0};
    #1;
    push({32'h99, 32'h0}); pop_check("bypass_port0_to_rd1", bus0.rd_data);
    tick();
    drv0(2'b00, 0, 0, 0, 0);

    // Fill, then clear request in RUN
    for (int i = 1; i < 32; i += 2) begin
      drv0(2'b11, 5'(i), 32'(i), 5'(i + 1), 32'(i + 1));
      tick();
    end
    drv0(2'b00, 0, 0, 0, 0);
    bus0.rd_addr = {5'd31, 5'd1};
    #1;
    push({32'd31, 32'd1}); pop_check("fill", bus0.rd_data);
    bus0.clr = 1'b1;
    drv0(2'b01, 5'd3, 32'hBAD, 5'd0, 32'h0);
    tick();
    bus0.clr = 1'b0;
    drv0(2'b11, 5'd4, 32'hFFFF, 5'd5, 32'hFFFF);
    n0 = 0; zbad = 0;
    while (!bus0.ready && n0 < 100) begin
      bus0.rd_addr = {5'(n0 % 31 + 1), 5'd4};
      bus0.clr = (n0 == 5);
      #1;
      if (bus0.rd_data != '0) zbad++;
      tick();
      n0++;
    end
    bus0.clr = 1'b0;
    drv0(2'b00, 0, 0, 0, 0);
    push(64'd31); pop_check("clr_clear_len", n0);
    push(64'd0);  pop_check("clr_reads_zero", zbad);
    read_all_zero0("wiped_after_clr");

    // Reset in the middle of a clear walk restarts it
    bus0.clr = 1'b1;
    tick();
    bus0.clr = 1'b0;
    repeat (9) tick();
    rst0 = 1'b0;
    #1;
    push(64'h0); pop_check("midclear_rst_ready", bus0.ready);
    tick();
    rst0 = 1'b1;
    n0 = 0;
    while (!bus0.ready && n0 < 100) begin tick(); n0++; end
    push(64'd31); pop_check("midclear_restart_len", n0);

    // Four read ports, narrow data, shallow array
    drv2(2'b11, 3'd1, 16'hA001, 3'd2, 16'hB002);
    tick();
    drv2(2'b11, 3'd3, 16'hC003, 3'd7, 16'hD007);
    tick();
    drv2(2'b00, 0, 0, 0, 0);
    bus2.rd_addr = {3'd0, 3'd3, 3'd2, 3'd1};
    #1;
    push({16'h0, 16'hC003, 16'hB002, 16'hA001}); pop_check("nrd4_reads", bus2.rd_data);
    bus2.rd_addr = {3'd7, 3'd7, 3'd0, 3'd7};
    #1;
    push({16'hD007, 16'hD007, 16'h0, 16'hD007}); pop_check("nrd4_top_entry", bus2.rd_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
